int_issue_queue: RTL

- Reservation-station style issue queue in front of the integer execution unit.
- Accepts dispatched integer and branch instructions and holds them until both source operands are available.
- Operands are captured by snooping the common data bus.
- Presents the oldest ready entry to the execution unit as int_fifo_data with an issue request, and retires it from the queue on grant.

---
 rtl/int_issue_queue_pkg.sv | 60 ++++++
 rtl/int_issue_queue_rs_slot.sv | 37 +++
 rtl/int_issue_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/int_issue_queue_pkg.sv
// Shared types for the integer issue queue: dispatch payload, CDB snoop bus,
// reservation-station entry and the common wakeup helper.
package int_issue_queue_pkg;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   localparam logic [6:0] R_TYPE      = 7'b0110011;
   localparam logic [6:0] I_TYPE      = 7'b0010011;
   localparam logic [6:0] LUI_TYPE    = 7'b0110111;
   localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

   typedef struct packed {
      logic [6:0]       opcode;
      logic [2:0]       func3;
      logic [6:0]       func7;
      logic [TAG_W-1:0] rd_tag;
      logic [XLEN-1:0]  rs1_data;
      logic [XLEN-1:0]  rs2_data;
   } int_fifo_data;

   typedef struct packed {
      logic             cdb_valid;
      logic [TAG_W-1:0] cdb_tag;
      logic [XLEN-1:0]  cdb_result;
   } cdb_bfm;

   typedef struct packed {
      logic             valid;
      int_fifo_data     data;
      logic [TAG_W-1:0] rs1_tag;
      logic             rs1_rdy;
      logic [TAG_W-1:0] rs2_tag;
      logic             rs2_rdy;
   } int_rs_entry;

   // Capture a CDB result into any waiting source of a valid entry.
   function automatic int_rs_entry rs_wakeup(input int_rs_entry e, input cdb_bfm cdb);
      int_rs_entry w;
      w = e;
      if (e.valid && cdb.cdb_valid) begin
         if (!e.rs1_rdy && (e.rs1_tag == cdb.cdb_tag)) begin
            w.rs1_rdy       = 1'b1;
            w.data.rs1_data = cdb.cdb_result;
         end else begin
            w.rs1_rdy = e.rs1_rdy;
         end
         if (!e.rs2_rdy && (e.rs2_tag == cdb.cdb_tag)) begin
            w.rs2_rdy       = 1'b1;
            w.data.rs2_data = cdb.cdb_result;
         end else begin
            w.rs2_rdy = e.rs2_rdy;
         end
      end else begin
         w = e;
      end
      return w;
   endfunction

endpackage

// File: rtl/int_issue_queue_rs_slot.sv
// One issue-queue slot: entry register with CDB wakeup, dispatch load and
// shift-down from the slot above.
module int_rs_slot
   import int_issue_queue_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  cdb_bfm      cdb,
   input  logic        clear,
   input  logic        load,
   input  int_rs_entry load_entry,
   input  logic        shift,
   input  int_rs_entry upper,
   output int_rs_entry entry,
   output int_rs_entry woken,
   output logic        ready
);

   assign woken = rs_wakeup(entry, cdb);
   assign ready = entry.valid & entry.rs1_rdy & entry.rs2_rdy;

   // Shifted-in contents already carry this cycle's wakeup from the upper slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry <= '0;
      end else if (clear) begin
         entry <= '0;
      end else if (load) begin
         entry <= load_entry;
      end else if (shift) begin
         entry <= upper;
      end else begin
         entry <= woken;
      end
   end

endmodule

// File: rtl/int_issue_queue.sv
// Age-ordered integer issue queue: oldest-ready select, compacting shift on
// grant, CDB wakeup with dispatch bypass, and occupancy/full tracking.
module int_issue_queue
   import int_issue_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_dispatch_valid,
   input  int_fifo_data     i_dispatch_data,
   input  logic [TAG_W-1:0] i_rs1_tag,
   input  logic             i_rs1_rdy,
   input  logic [TAG_W-1:0] i_rs2_tag,
   input  logic             i_rs2_rdy,
   input  cdb_bfm           i_cdb,
   output logic             o_queue_full,
   output logic             o_issue_req,
   output int_fifo_data     o_int_exec_fifo_data,
   input  logic             i_issue_granted,
   output logic [CNT_W-1:0] o_count
);

   int_rs_entry      entries [DEPTH];
   int_rs_entry      woken   [DEPTH];
   int_rs_entry      upper   [DEPTH];
   int_rs_entry      disp_raw;
   int_rs_entry      disp_entry;
   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] at_or_above_sel;
   logic [DEPTH-1:0] load;
   logic             any_ready;
   int_fifo_data     sel_data;
   logic             grant_fire;
   logic             dispatch_ok;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] wr_idx;
   logic             full;

   // Priority select of the oldest ready entry; the mask marks slots that shift on grant.
   always_comb begin
      any_ready       = 1'b0;
      sel_data        = '0;
      at_or_above_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel_data           = (ready[i] && !any_ready) ? entries[i].data : sel_data;
         any_ready          = any_ready | ready[i];
         at_or_above_sel[i] = any_ready;
      end
   end

   assign grant_fire  = i_issue_granted & any_ready & ~i_flush;
   assign dispatch_ok = i_dispatch_valid & ~full & ~i_flush;
   assign wr_idx      = count - CNT_W'(grant_fire);

   always_comb begin
      disp_raw         = '0;
      disp_raw.valid   = 1'b1;
      disp_raw.data    = i_dispatch_data;
      disp_raw.rs1_tag = i_rs1_tag;
      disp_raw.rs1_rdy = i_rs1_rdy;
      disp_raw.rs2_tag = i_rs2_tag;
      disp_raw.rs2_rdy = i_rs2_rdy;
   end

   // Bypass: a broadcast in the dispatch cycle must not be lost.
   assign disp_entry = rs_wakeup(disp_raw, i_cdb);

   // Occupancy update for the four dispatch/grant combinations.
   always_comb begin
      case ({dispatch_ok, grant_fire})
         2'b10:   count_next = count + {{(CNT_W-1){1'b0}}, 1'b1};
         2'b01:   count_next = count - {{(CNT_W-1){1'b0}}, 1'b1};
         default: count_next = count;
      endcase
   end

   // Occupancy and registered full flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         full  <= 1'b0;
      end else if (i_flush) begin
         count <= '0;
         full  <= 1'b0;
      end else begin
         count <= count_next;
         full  <= (count_next == CNT_W'(DEPTH));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      if (g == DEPTH - 1) begin : g_top
         assign upper[g] = '0;
      end else begin : g_mid
         assign upper[g] = woken[g+1];
      end

      assign load[g] = dispatch_ok & (wr_idx == CNT_W'(g));

      int_rs_slot u_slot (
         .clk        (clk),
         .rst_n      (rst_n),
         .cdb        (i_cdb),
         .clear      (i_flush),
         .load       (load[g]),
         .load_entry (disp_entry),
         .shift      (grant_fire & at_or_above_sel[g]),
         .upper      (upper[g]),
         .entry      (entries[g]),
         .woken      (woken[g]),
         .ready      (ready[g])
      );
   end

   assign o_queue_full         = full;
   assign o_issue_req          = any_ready;
   assign o_int_exec_fifo_data = sel_data;
   assign o_count              = count;

endmodule
